// File: rtl/regfile_sequencer.sv
// Command sequencer for the 8-entry register file (R1-R4, S1-S4).
// Carries out one handshaked register command at a time over one or three execute cycles.
module regfile_sequencer #(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             cmd_valid,
   output logic             cmd_ready,
   input  logic [2:0]       cmd_op,
   input  logic [2:0]       cmd_dst,
   input  logic [2:0]       cmd_src,
   input  logic [WIDTH-1:0] cmd_imm,
   output logic             done,
   output logic             err,
   output logic [2:0]       out_a_sel,
   output logic [2:0]       out_b_sel,
   output logic [3:0]       reg_sel,
   output logic [3:0]       scr_sel,
   output logic [2:0]       fun_sel,
   output logic [WIDTH-1:0] i,
   input  logic [WIDTH-1:0] reg_out_a
);

   localparam logic [2:0] OP_MOV  = 3'b000;
   localparam logic [2:0] OP_LDI  = 3'b001;
   localparam logic [2:0] OP_CLR  = 3'b010;
   localparam logic [2:0] OP_INC  = 3'b011;
   localparam logic [2:0] OP_DEC  = 3'b100;
   localparam logic [2:0] OP_SWAP = 3'b101;

   localparam logic [2:0] FUN_LOAD  = 3'b010;
   localparam logic [2:0] FUN_CLEAR = 3'b011;
   localparam logic [2:0] FUN_INC   = 3'b001;
   localparam logic [2:0] FUN_DEC   = 3'b000;

   typedef enum logic [2:0] {IDLE, EX1, EX2, EX3, DONE} state_t;

   state_t           state, state_next;
   logic [2:0]       op_q, dst_q, src_q;
   logic [WIDTH-1:0] imm_q, temp_q;
   logic             done_q, err_q;
   logic             accept, temp_load, err_set;
   logic [7:0]       wr_n, dst_mask, src_mask;

   assign cmd_ready = (state == IDLE);
   assign accept    = cmd_valid && cmd_ready;
   assign done      = done_q;
   assign err       = err_q;

   // Enables are packed {R1..R4, S1..S4}, so index k is simply bit 7-k.
   assign dst_mask = ~(8'h80 >> dst_q);
   assign src_mask = ~(8'h80 >> src_q);
   assign {reg_sel, scr_sel} = wr_n;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state  <= IDLE;
         op_q   <= '0;
         dst_q  <= '0;
         src_q  <= '0;
         imm_q  <= '0;
         temp_q <= '0;
         done_q <= 1'b0;
         err_q  <= 1'b0;
      end else begin
         state  <= state_next;
         done_q <= (state_next == DONE);
         if (accept) begin
            op_q  <= cmd_op;
            dst_q <= cmd_dst;
            src_q <= cmd_src;
            imm_q <= cmd_imm;
            err_q <= 1'b0;
         end
         if (err_set) begin
            err_q <= 1'b1;
         end
         if (temp_load) begin
            temp_q <= reg_out_a;
         end
      end
   end

   always_comb begin
      state_next = state;
      out_a_sel  = 3'd0;
      out_b_sel  = (state == IDLE) ? 3'd0 : src_q;
      fun_sel    = FUN_LOAD;
      i          = '0;
      wr_n       = 8'hFF;
      temp_load  = 1'b0;
      err_set    = 1'b0;
      unique case (state)
         IDLE: begin
            if (accept) begin
               state_next = EX1;
            end
         end
         EX1: begin
            state_next = DONE;
            case (op_q)
               OP_MOV: begin
                  out_a_sel = src_q;
                  i         = reg_out_a;
                  wr_n      = dst_mask;
               end
               OP_LDI: begin
                  i    = imm_q;
                  wr_n = dst_mask;
               end
               OP_CLR: begin
                  fun_sel = FUN_CLEAR;
                  wr_n    = dst_mask;
               end
               OP_INC: begin
                  fun_sel = FUN_INC;
                  wr_n    = dst_mask;
               end
               OP_DEC: begin
                  fun_sel = FUN_DEC;
                  wr_n    = dst_mask;
               end
               OP_SWAP: begin
                  // Degenerate swap retires without touching Temp or the file.
                  out_a_sel = dst_q;
                  if (src_q != dst_q) begin
                     temp_load  = 1'b1;
                     state_next = EX2;
                  end
               end
               default: begin
                  err_set = 1'b1;
               end
            endcase
         end
         EX2: begin
            out_a_sel  = src_q;
            i          = reg_out_a;
            wr_n       = dst_mask;
            state_next = EX3;
         end
         EX3: begin
            i          = temp_q;
            wr_n       = src_mask;
            state_next = DONE;
         end
         DONE: begin
            state_next = IDLE;
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

endmodule

// File: tb/tb_regfile_sequencer.sv
// Bench for regfile_sequencer: a behavioural register file closes the loop and
// a command-level model predicts file contents, latency and error flags.
module tb_regfile_sequencer;

   localparam int WIDTH = 16;

   logic             clk = 1'b0;
   logic             rst_n = 1'b0;
   logic             cmd_valid = 1'b0;
   logic             cmd_ready;
   logic [2:0]       cmd_op = '0;
   logic [2:0]       cmd_dst = '0;
   logic [2:0]       cmd_src = '0;
   logic [WIDTH-1:0] cmd_imm = '0;
   logic             done, err;
   logic [2:0]       out_a_sel, out_b_sel;
   logic [3:0]       reg_sel, scr_sel;
   logic [2:0]       fun_sel;
   logic [WIDTH-1:0] rf_i;
   logic [WIDTH-1:0] reg_out_a;

   logic [WIDTH-1:0] rf [8] = '{default: '0};
   logic [WIDTH-1:0] exp_rf [8] = '{default: '0};
   logic [7:0]       wr_n;
   bit               nowrite_active = 1'b0;

   int total = 0;
   int bad = 0;

   regfile_sequencer #(.WIDTH(WIDTH)) dut (
      .clk(clk), .rst_n(rst_n),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
      .cmd_op(cmd_op), .cmd_dst(cmd_dst), .cmd_src(cmd_src), .cmd_imm(cmd_imm),
      .done(done), .err(err),
      .out_a_sel(out_a_sel), .out_b_sel(out_b_sel),
      .reg_sel(reg_sel), .scr_sel(scr_sel), .fun_sel(fun_sel),
      .i(rf_i), .reg_out_a(reg_out_a)
   );

   always #5 clk = ~clk;

   assign wr_n      = {reg_sel, scr_sel};
   assign reg_out_a = rf[out_a_sel];

   // Register file: index k (R1..R4 = 0..3, S1..S4 = 4..7) writes when its bit is low.
   always @(posedge clk) begin
      for (int k = 0; k < 8; k++) begin
         if (!wr_n[7-k]) begin
            case (fun_sel)
               3'b010:  rf[k] <= rf_i;
               3'b011:  rf[k] <= '0;
               3'b001:  rf[k] <= rf[k] + 1'b1;
               3'b000:  rf[k] <= rf[k] - 1'b1;
               default: rf[k] <= rf[k];
            endcase
         end
      end
   end

   // At most one enable low at any time, none while Done or during a no-write command.
   always @(negedge clk) begin
      if (rst_n) begin
         total++;
         if ($countones(~wr_n) > 1 || ((done || nowrite_active) && wr_n != 8'hFF)) begin
            bad++;
            $display("[TB] FAIL enables: got %b required one-hot-low or none", wr_n);
         end
      end
   end

   task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("[TB] FAIL %s: got %h required %h", name, act, exp);
      end
   endtask

   // Command-level reference: what the file must hold after a command retires.
   task automatic model_cmd(input logic [2:0] op, dst, src, input logic [WIDTH-1:0] imm);
      logic [WIDTH-1:0] t;
      case (op)
         3'd0: exp_rf[dst] = exp_rf[src];
         3'd1: exp_rf[dst] = imm;
         3'd2: exp_rf[dst] = '0;
         3'd3: exp_rf[dst] = exp_rf[dst] + 1'b1;
         3'd4: exp_rf[dst] = exp_rf[dst] - 1'b1;
         3'd5: begin
            t = exp_rf[dst];
            exp_rf[dst] = exp_rf[src];
            exp_rf[src] = t;
         end
         default: ;
      endcase
   endtask

   task automatic check_file();
      for (int k = 0; k < 8; k++) begin
         check_output($sformatf("rf[%0d]", k), 32'(rf[k]), 32'(exp_rf[k]));
      end
   endtask

   task automatic apply_stimulus(input logic [2:0] op, dst, src, input logic [WIDTH-1:0] imm,
                                 output logic [7:0] ex1_wr, output logic [2:0] ex1_fun,
                                 output logic [WIDTH-1:0] ex1_i);
      int  n;
      bit  ready_busy;
      bit  is_err;
      bit  no_write;
      int  exp_lat;
      is_err   = (op >= 3'd6);
      no_write = is_err || (op == 3'd5 && dst == src);
      exp_lat  = (op == 3'd5 && dst != src) ? 4 : 2;
      ex1_wr   = 8'hFF;
      ex1_fun  = '0;
      ex1_i    = '0;
      cmd_valid = 1'b1;
      cmd_op    = op;
      cmd_dst   = dst;
      cmd_src   = src;
      cmd_imm   = imm;
      n = 0;
      while (!cmd_ready && n < 20) begin
         @(negedge clk);
         n++;
      end
      check_output("ready_before_accept", 32'(cmd_ready), 32'd1);
      @(posedge clk);
      #1;
      nowrite_active = no_write;
      cmd_valid = 1'b0;
      cmd_op    = 3'($urandom);
      cmd_dst   = 3'($urandom);
      cmd_src   = 3'($urandom);
      cmd_imm   = WIDTH'($urandom);
      n = 0;
      ready_busy = 1'b0;
      while (n < 20) begin
         @(negedge clk);
         n++;
         if (n == 1) begin
            ex1_wr  = wr_n;
            ex1_fun = fun_sel;
            ex1_i   = rf_i;
         end
         if (cmd_ready) ready_busy = 1'b1;
         if (done) break;
      end
      check_output("done_latency", 32'(n), 32'(exp_lat));
      check_output("err_with_done", 32'(err), 32'(is_err));
      check_output("ready_while_busy", 32'(ready_busy), 32'd0);
      @(negedge clk);
      check_output("done_one_cycle", 32'(done), 32'd0);
      nowrite_active = 1'b0;
      model_cmd(op, dst, src, imm);
      check_file();
   endtask

   typedef struct {
      logic [2:0]       op;
      logic [2:0]       dst;
      logic [2:0]       src;
      logic [WIDTH-1:0] imm;
      int               chk_idx;
      logic [WIDTH-1:0] chk_val;
   } vec_t;

   initial begin
      vec_t             vecs [12];
      logic [7:0]       w;
      logic [2:0]       f;
      logic [WIDTH-1:0] d;

      vecs[0]  = '{3'd1, 3'd0, 3'd0, 16'h1234, 0, 16'h1234};
      vecs[1]  = '{3'd1, 3'd5, 3'd0, 16'h00FF, 5, 16'h00FF};
      vecs[2]  = '{3'd5, 3'd0, 3'd5, 16'h0000, 0, 16'h00FF};
      vecs[3]  = '{3'd1, 3'd3, 3'd0, 16'hFFFF, 3, 16'hFFFF};
      vecs[4]  = '{3'd3, 3'd3, 3'd1, 16'h5555, 3, 16'h0000};
      vecs[5]  = '{3'd4, 3'd7, 3'd2, 16'h0000, 7, 16'hFFFF};
      vecs[6]  = '{3'd2, 3'd4, 3'd0, 16'h0000, 4, 16'h0000};
      vecs[7]  = '{3'd7, 3'd1, 3'd0, 16'h7777, 1, 16'h0000};
      vecs[8]  = '{3'd0, 3'd1, 3'd0, 16'h0000, 1, 16'h00FF};
      vecs[9]  = '{3'd1, 3'd6, 3'd0, 16'hABCD, 6, 16'hABCD};
      vecs[10] = '{3'd5, 3'd6, 3'd6, 16'h0000, 6, 16'hABCD};
      vecs[11] = '{3'd0, 3'd2, 3'd2, 16'h0000, 2, 16'h0000};

      #12;
      check_output("reset_ready", 32'(cmd_ready), 32'd1);
      check_output("reset_wr_n", 32'(wr_n), 32'hFF);
      check_output("reset_fun_sel", 32'(fun_sel), 32'd2);
      check_output("reset_i", 32'(rf_i), 32'd0);
      check_output("reset_sels", 32'({out_a_sel, out_b_sel}), 32'd0);
      check_output("reset_done_err", 32'({done, err}), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      foreach (vecs[k]) begin
         apply_stimulus(vecs[k].op, vecs[k].dst, vecs[k].src, vecs[k].imm, w, f, d);
         check_output($sformatf("vec%0d_value", k), 32'(rf[vecs[k].chk_idx]), 32'(vecs[k].chk_val));
      end
      check_output("swap_s2", 32'(rf[5]), 32'h1234);

      apply_stimulus(3'd1, 3'd2, 3'd0, 16'hBEEF, w, f, d);
      check_output("ldi_ex1_wr", 32'(w), 32'hDF);
      check_output("ldi_ex1_fun", 32'(f), 32'd2);
      check_output("ldi_ex1_i", 32'(d), 32'hBEEF);
      check_output("ldi_r3", 32'(rf[2]), 32'hBEEF);

      cmd_valid = 1'b1;
      cmd_op    = 3'd5;
      cmd_dst   = 3'd1;
      cmd_src   = 3'd2;
      @(posedge clk);
      #1;
      cmd_valid = 1'b0;
      @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      check_output("rst_mid_wr_n", 32'(wr_n), 32'hFF);
      check_output("rst_mid_ready", 32'(cmd_ready), 32'd1);
      check_output("rst_mid_done", 32'(done), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      check_file();
      check_output("rst_mid_dst", 32'(rf[1]), 32'h00FF);
      apply_stimulus(3'd5, 3'd1, 3'd2, 16'h0000, w, f, d);
      check_output("after_rst_swap", 32'(rf[1]), 32'hBEEF);

      for (int n = 0; n < 40; n++) begin
         apply_stimulus(3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)),
                        3'($urandom_range(0, 7)), WIDTH'($urandom), w, f, d);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: got timeout required completion");
      $fatal(1, "[TB] watchdog expired");
   end

endmodule

// File: doc/regfile_sequencer.md
# regfile_sequencer

Command sequencer for the 8-entry register file (R1–R4 general, S1–S4 scratch). Accepts one register-level command at a time over a valid/ready handshake and drives the register file's select, enable and function lines, plus its data input, to carry the command out over one or three cycles. Sits between the instruction control unit and the register file. It is the only block allowed to drive the register file's write enables.

## Interface
Parameters:
- WIDTH, 16, data width of the register file and the immediate.

Ports:
- Clock  in  1  system clock; all state changes on the rising edge.
- Reset  in  1  asynchronous reset, active-low.
- CmdValid  in  1  command present.
- CmdReady  out  1  sequencer can accept a command.
- CmdOp  in  3  operation: 000 MOV, 001 LDI, 010 CLR, 011 INC, 100 DEC, 101 SWAP, 11x illegal.
- CmdDst  in  3  destination index.
- CmdSrc  in  3  source index.
- CmdImm  in  WIDTH  immediate value for LDI.
- Done  out  1  one-cycle pulse when a command retires.
- Err  out  1  valid with Done; high when the retired command was illegal.
- OutASel  out  3  register file port-A read select.
- OutBSel  out  3  register file port-B read select.
- RegSel  out  4  active-low write enables; bit 3 is R1, bit 0 is R4.
- ScrSel  out  4  active-low write enables; bit 3 is S1, bit 0 is S4.
- FunSel  out  3  register function: 010 load, 011 clear, 001 increment, 000 decrement.
- I  out  WIDTH  register file data input.
- RegOutA  in  WIDTH  register file OutA, fed back.

## Operation
- Register indexing: indices 0–3 map to R1–R4, indices 4–7 map to S1–S4. Index k clears only its own enable bit. All other enable bits stay 1.
- Accept condition: CmdValid && CmdReady at a rising edge. On accept, CmdOp, CmdDst, CmdSrc and CmdImm are captured into internal registers. Later changes on the Cmd* inputs are ignored.
- All outputs except Done and Err are decoded combinationally from the state and the captured fields.
- States:
  - IDLE: CmdReady=1; RegSel=ScrSel=4'b1111; OutASel=OutBSel=0; FunSel=010; I=0. On accept, go to EX1.
  - EX1, single-write ops, then DONE:
    - MOV: OutASel=src; I=RegOutA; FunSel=010; write dst.
    - LDI: I=imm; FunSel=010; write dst.
    - CLR / INC / DEC: I=0; FunSel=011 / 001 / 000 respectively; write dst.
  - EX1, SWAP: OutASel=dst; no write; Temp<=RegOutA at the edge; go to EX2. If src==dst: no write, no Temp load, go straight to DONE.
  - EX1, illegal op: no write; Err<=1; go to DONE.
  - EX2 (SWAP only): OutASel=src; I=RegOutA; FunSel=010; write dst; go to EX3.
  - EX3 (SWAP only): I=Temp; FunSel=010; write src; go to DONE.
  - DONE: Done=1; Err holds the result; CmdReady=0; no writes; go to IDLE.
- OutBSel equals the captured src in every state except IDLE.
- Err is cleared on each accept.
- MOV with src==dst performs a normal self-load; this is legal and not an error.
- CmdReady=0 in every state except IDLE. No command is queued.

## Timing
- Reset (Reset low, asynchronous):
  - Forces state to IDLE; clears Temp, the captured fields, Done and Err.
  - Outputs take their IDLE values immediately: CmdReady=1, RegSel=ScrSel=4'b1111, OutASel=OutBSel=0, FunSel=010, I=0.
- Reset mid-command: write enables drop asynchronously. A partially executed SWAP leaves the register file in whatever state it had reached; no rollback.
- Single-write ops, with the command accepted at edge 0:
  - The register is written at edge 1.
  - Done is high between edge 1 and edge 2.
  - The next accept is possible at edge 3, giving 3 cycles per command.
- SWAP, accepted at edge 0:
  - dst is written at edge 2 and src at edge 3.
  - Done is high between edge 3 and edge 4.
  - 5 cycles per command.
- Illegal op or degenerate SWAP (src==dst): Done and Err behave like a single-write op, with no write performed.
- RegOutA is used combinationally within the same cycle. The register file read path must settle within one cycle.

## Test plan
- Reset low mid-EX2 of a SWAP → RegSel=ScrSel=4'b1111 immediately, CmdReady=1, Done=0, dst unchanged; the next command executes normally.
- LDI dst=2, imm=16'hBEEF → EX1 shows RegSel=4'b1101, FunSel=010, I=16'hBEEF; R3 reads 16'hBEEF afterwards; Done pulses exactly 1 cycle with Err=0.
- With R1=16'h1234, S2=16'h00FF: SWAP dst=0, src=5 → R1=16'h00FF and S2=16'h1234; Done 4 cycles after accept; CmdValid held high shows CmdReady low for 4 cycles.
- With R4=16'hFFFF: INC dst=3 → R4=16'h0000. Then DEC dst=7 with S4=0 → S4=16'hFFFF. Then CLR dst=4 → S1=0; only the addressed enable bit is ever low.
- CmdOp=3'b111 → no enable asserted in any cycle; Done=1 with Err=1. The following MOV retires with Err=0.
- SWAP src=dst=6 → no write; Done 2 cycles after accept; S3 unchanged.
